// File: rtl/col2img_writer.sv
// col2img_writer: collects one output pixel per beat (all kernels at once),
// requantizes each accumulator to BITWIDTH bits and assembles the complete
// set of output feature maps, which is then offered with a valid/ready handshake.
module col2img_writer #(
    parameter int unsigned BITWIDTH   = 8,
    parameter int unsigned ACC_WIDTH  = 20,
    parameter int unsigned OUT_WIDTH  = 3,
    parameter int unsigned OUT_HEIGHT = 3,
    parameter int unsigned KERNEL_NUM = 3,
    parameter int unsigned SHIFT      = 0
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic [KERNEL_NUM*ACC_WIDTH-1:0]                   in_data,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [KERNEL_NUM*OUT_HEIGHT*OUT_WIDTH*BITWIDTH-1:0] feature_maps,
    output logic                                              busy
);

    localparam int unsigned PIX_NUM = OUT_HEIGHT * OUT_WIDTH;
    localparam int unsigned FM_BITS = KERNEL_NUM * PIX_NUM * BITWIDTH;
    localparam int unsigned ROW_W   = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
    localparam int unsigned COL_W   = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_WIDTH - 1);

    localparam logic signed [ACC_WIDTH-1:0] Q_MAX = ACC_WIDTH'((2 ** (BITWIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] Q_MIN = ACC_WIDTH'(-(2 ** (BITWIDTH - 1)));

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [ROW_W-1:0]     row, row_next;
    logic [COL_W-1:0]     col, col_next;
    logic                 beat;
    logic                 frame_clr;
    logic                 in_ready_next, out_valid_next, busy_next;
    logic [PIX_NUM-1:0]   pix_we;
    logic [FM_BITS-1:0]   fm_next;
    logic [BITWIDTH-1:0]  q [KERNEL_NUM];

    // Arithmetic shift then clamp to the signed BITWIDTH range (truncating, no rounding).
    function automatic logic [BITWIDTH-1:0] requant(input logic signed [ACC_WIDTH-1:0] acc);
        logic signed [ACC_WIDTH-1:0] sh;
        sh = acc >>> SHIFT;
        if (sh > Q_MAX) begin
            return Q_MAX[BITWIDTH-1:0];
        end else if (sh < Q_MIN) begin
            return Q_MIN[BITWIDTH-1:0];
        end else begin
            return sh[BITWIDTH-1:0];
        end
    endfunction

    // Next-state, counter advance and registered-output decode.
    always_comb begin
        state_next = state;
        row_next   = row;
        col_next   = col;
        beat       = 1'b0;
        frame_clr  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = COLLECT;
                    row_next   = '0;
                    col_next   = '0;
                    frame_clr  = 1'b1;
                end
            end
            COLLECT: begin
                if (in_valid && in_ready) begin
                    beat = 1'b1;
                    if (col == COL_LAST) begin
                        col_next = '0;
                        if (row == ROW_LAST) begin
                            row_next   = '0;
                            state_next = DONE;
                        end else begin
                            row_next = row + 1'b1;
                        end
                    end else begin
                        col_next = col + 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        in_ready_next  = (state_next == COLLECT);
        out_valid_next = (state_next == DONE);
        busy_next      = (state_next != IDLE);
    end

    // Per-kernel requantized values of the current beat.
    for (genvar k = 0; k < KERNEL_NUM; k++) begin : g_q
        assign q[k] = requant(in_data[(KERNEL_NUM-1-k)*ACC_WIDTH +: ACC_WIDTH]);
    end

    // Pixel write enables decoded from the row/col position.
    for (genvar r = 0; r < OUT_HEIGHT; r++) begin : g_we_r
        for (genvar c = 0; c < OUT_WIDTH; c++) begin : g_we_c
            assign pix_we[r*OUT_WIDTH + c] = beat && (row == ROW_W'(r)) && (col == COL_W'(c));
        end
    end

    // Next buffer contents: clear on frame start, write the addressed pixel of every map.
    for (genvar k = 0; k < KERNEL_NUM; k++) begin : g_fm_k
        for (genvar p = 0; p < PIX_NUM; p++) begin : g_fm_p
            localparam int unsigned LSB = FM_BITS - (k*PIX_NUM + p + 1) * BITWIDTH;
            assign fm_next[LSB +: BITWIDTH] = frame_clr ? '0 :
                                              pix_we[p] ? q[k] :
                                              feature_maps[LSB +: BITWIDTH];
        end
    end

    // State, counters, buffer and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            row          <= '0;
            col          <= '0;
            feature_maps <= '0;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            row          <= row_next;
            col          <= col_next;
            feature_maps <= fm_next;
            in_ready     <= in_ready_next;
            out_valid    <= out_valid_next;
            busy         <= busy_next;
        end
    end

endmodule

// File: tb/tb_col2img_writer.sv
// Bench for col2img_writer: randomized and directed frames into a default
// instance (SHIFT=0), a SHIFT=2 instance sharing its inputs, and a 4x2
// single-kernel instance; a scoreboard compares each delivered frame.
module tb_col2img_writer;

    localparam int NPIX  = 9;
    localparam int NK    = 3;
    localparam int FMW   = 216;
    localparam int NPIX2 = 8;

    logic clk;
    logic rst;
    logic start, in_valid, out_ready;
    logic [59:0] in_data;
    logic in_ready0, out_valid0, busy0;
    logic in_ready1, out_valid1, busy1;
    logic [FMW-1:0] fm0, fm1;

    logic start2, in_valid2, out_ready2;
    logic [19:0] in_data2;
    logic in_ready2, out_valid2, busy2;
    logic [63:0] fm2;

    int checks;
    int failures;
    int pix_v [NPIX][NK];
    int pv2 [NPIX2];
    logic [FMW-1:0] exp0 [$];
    logic [FMW-1:0] exp1 [$];
    logic [63:0]    exp2 [$];
    logic [FMW-1:0] e0, e1;
    logic [63:0]    e2;

    localparam logic [FMW-1:0] BASIC_FM =
        216'h010203040506070809_111213141516171819_212223242526272829;

    col2img_writer u0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .feature_maps(fm0), .busy(busy0)
    );

    col2img_writer #(.SHIFT(2)) u1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .feature_maps(fm1), .busy(busy1)
    );

    col2img_writer #(.OUT_WIDTH(4), .OUT_HEIGHT(2), .KERNEL_NUM(1)) u2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .feature_maps(fm2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [FMW-1:0] act, input logic [FMW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: element = clamp(floor(v / 2^shift)), packed map-major, pixel-major, first in MSBs.
    function automatic logic [FMW-1:0] model(input int shift);
        logic [FMW-1:0] r;
        int v;
        r = '0;
        for (int k = 0; k < NK; k++) begin
            for (int p = 0; p < NPIX; p++) begin
                v = pix_v[p][k] >>> shift;
                if (v > 127) v = 127;
                if (v < -128) v = -128;
                r = (r << 8) | FMW'(v & 255);
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] model2();
        logic [63:0] r;
        int v;
        r = '0;
        for (int p = 0; p < NPIX2; p++) begin
            v = pv2[p];
            if (v > 127) v = 127;
            if (v < -128) v = -128;
            r = (r << 8) | 64'(v & 255);
        end
        return r;
    endfunction

    function automatic int rand_val();
        if ($urandom_range(3, 0) == 0) return int'($urandom_range(1048575, 0)) - 524288;
        return int'($urandom_range(400, 0)) - 200;
    endfunction

    task automatic fill_directed();
        for (int p = 0; p < NPIX; p++)
            for (int k = 0; k < NK; k++)
                pix_v[p][k] = p + 1 + 16 * k;
    endtask

    task automatic fill_random();
        for (int p = 0; p < NPIX; p++)
            for (int k = 0; k < NK; k++)
                pix_v[p][k] = rand_val();
    endtask

    // gap_mode: 0 none, 1 one idle cycle per beat, 2 random gaps.
    // abort_after > 0: pulse reset after that many accepted beats.
    task automatic run_frame(input int gap_mode, input int abort_after,
                             input bit start_glitch, input int hold);
        if (abort_after == 0) begin
            exp0.push_back(model(0));
            exp1.push_back(model(2));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < NPIX; b++) begin
            if (gap_mode == 1) begin
                in_valid = 1'b0;
                in_data  = 60'($urandom());
                tick();
            end else if (gap_mode == 2) begin
                repeat ($urandom_range(2, 0)) begin
                    in_valid = 1'b0;
                    in_data  = 60'($urandom());
                    tick();
                end
            end
            in_valid = 1'b1;
            for (int k = 0; k < NK; k++) in_data[(2-k)*20 +: 20] = 20'(pix_v[b][k]);
            if (start_glitch && b == 5) start = 1'b1;
            tick();
            start = 1'b0;
            if (abort_after > 0 && b == abort_after - 1) begin
                rst = 1'b1;
                start = 1'b1;
                in_valid = 1'b1;
                tick();
                rst = 1'b0;
                start = 1'b0;
                in_valid = 1'b0;
                @(negedge clk);
                chk("abort_busy", FMW'(busy0), FMW'(0));
                chk("abort_in_ready", FMW'(in_ready0), FMW'(0));
                chk("abort_fm", fm0, '0);
                chk("abort_busy_s2", FMW'(busy1), FMW'(0));
                return;
            end
            if (b == NPIX - 2) begin
                @(negedge clk);
                chk("early_out_valid", FMW'(out_valid0), FMW'(0));
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_out_valid", FMW'(out_valid0), FMW'(1));
        chk("done_in_ready", FMW'(in_ready0), FMW'(0));
        for (int i = 0; i < hold; i++) begin
            tick();
            start = (start_glitch && i == 0);
            @(negedge clk);
            chk("hold_out_valid", FMW'(out_valid0), FMW'(1));
        end
        tick();
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_hs_busy", FMW'(busy0), FMW'(0));
        chk("post_hs_out_valid", FMW'(out_valid0), FMW'(0));
    endtask

    task automatic run_frame2(input bit directed);
        for (int p = 0; p < NPIX2; p++) pv2[p] = directed ? p + 1 : int'($urandom_range(600, 0)) - 300;
        exp2.push_back(model2());
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int b = 0; b < NPIX2; b++) begin
            in_valid2 = 1'b1;
            in_data2  = 20'(pv2[b]);
            tick();
            if (b == NPIX2 - 2) begin
                @(negedge clk);
                chk("ns_early_out_valid", FMW'(out_valid2), FMW'(0));
            end
        end
        in_valid2 = 1'b0;
        @(negedge clk);
        chk("ns_out_valid", FMW'(out_valid2), FMW'(1));
        if (directed) chk("ns_fm_const", FMW'(fm2), FMW'(64'h0102030405060708));
        tick();
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
    endtask

    // Scoreboard monitors: compare at every output handshake.
    always @(negedge clk) begin
        if (out_valid0 && out_ready) begin
            checks++;
            if (exp0.size() == 0) begin
                failures++;
                $display("FAIL sb0_unexpected actual=%0h required=none", fm0);
            end else begin
                e0 = exp0.pop_front();
                if (fm0 !== e0) begin
                    failures++;
                    $display("FAIL sb0_frame actual=%0h required=%0h", fm0, e0);
                end
            end
        end
        if (out_valid1 && out_ready) begin
            checks++;
            if (exp1.size() == 0) begin
                failures++;
                $display("FAIL sb1_unexpected actual=%0h required=none", fm1);
            end else begin
                e1 = exp1.pop_front();
                if (fm1 !== e1) begin
                    failures++;
                    $display("FAIL sb1_frame actual=%0h required=%0h", fm1, e1);
                end
            end
        end
        if (out_valid2 && out_ready2) begin
            checks++;
            if (exp2.size() == 0) begin
                failures++;
                $display("FAIL sb2_unexpected actual=%0h required=none", fm2);
            end else begin
                e2 = exp2.pop_front();
                if (fm2 !== e2) begin
                    failures++;
                    $display("FAIL sb2_frame actual=%0h required=%0h", fm2, e2);
                end
            end
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        start2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0; in_data2 = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", FMW'(busy0), FMW'(0));
        chk("rst_in_ready", FMW'(in_ready0), FMW'(0));
        chk("rst_out_valid", FMW'(out_valid0), FMW'(0));
        chk("rst_fm", fm0, '0);
        chk("rst_fm_ns", FMW'(fm2), FMW'(0));

        // Basic frame, back-to-back beats.
        fill_directed();
        run_frame(0, 0, 1'b0, 0);
        chk("basic_fm_const", fm0, BASIC_FM);

        // Saturation: pixel 0 carries 300, -300, -5.
        fill_random();
        pix_v[0][0] = 300; pix_v[0][1] = -300; pix_v[0][2] = -5;
        run_frame(0, 0, 1'b0, 1);
        chk("sat_pos", FMW'(fm0[215:208]), FMW'(8'h7F));
        chk("sat_neg", FMW'(fm0[143:136]), FMW'(8'h80));
        chk("sat_small_neg", FMW'(fm0[71:64]), FMW'(8'hFB));
        chk("shift2_pos", FMW'(fm1[215:208]), FMW'(8'h4B));
        chk("shift2_neg", FMW'(fm1[71:64]), FMW'(8'hFE));

        // Backpressure on both sides.
        fill_directed();
        run_frame(1, 0, 1'b0, 10);
        chk("bp_fm_const", fm0, BASIC_FM);

        // Reset mid-frame, then a clean frame.
        fill_random();
        run_frame(0, 4, 1'b0, 0);
        fill_directed();
        run_frame(0, 0, 1'b0, 0);
        chk("after_abort_fm_const", fm0, BASIC_FM);

        // start ignored in COLLECT and DONE.
        fill_random();
        run_frame(2, 0, 1'b1, 3);

        // Randomized frames.
        for (int n = 0; n < 6; n++) begin
            fill_random();
            run_frame(2, 0, 1'b0, int'($urandom_range(4, 0)));
        end

        // Non-square single-kernel geometry.
        run_frame2(1'b1);
        run_frame2(1'b0);
        run_frame2(1'b0);

        repeat (2) tick();
        chk("sb0_drain", FMW'(exp0.size()), FMW'(0));
        chk("sb1_drain", FMW'(exp1.size()), FMW'(0));
        chk("sb2_drain", FMW'(exp2.size()), FMW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/col2img_writer.md
COL2IMG_WRITER -- requirements
Module: col2img_writer

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8, output element width in bits (signed).
REQ-002 SHALL have parameter ACC_WIDTH, default 20, width in bits of each signed accumulator result from the systolic array.
REQ-003 SHALL have parameter OUT_WIDTH, default 3, output feature-map columns.
REQ-004 SHALL have parameter OUT_HEIGHT, default 3, output feature-map rows.
REQ-005 SHALL have parameter KERNEL_NUM, default 3, number of kernels, which equals the number of output maps.
REQ-006 SHALL have parameter SHIFT, default 0, requantization arithmetic right-shift amount.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-008 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-009 SHALL have port start, input, 1 bit, a single-cycle pulse that begins a frame.
REQ-010 SHALL have port in_valid, input, 1 bit, result-column beat valid.
REQ-011 SHALL have port in_ready, output, 1 bit, block accepts a beat.
REQ-012 SHALL have port in_data, input, KERNEL_NUM*ACC_WIDTH bits, one output pixel for all kernels; kernel 0 in the MSBs.
REQ-013 SHALL have port out_valid, output, 1 bit, the complete feature-map set is available.
REQ-014 SHALL have port out_ready, input, 1 bit, the consumer takes the feature maps.
REQ-015 SHALL have port feature_maps, output, KERNEL_NUM*OUT_HEIGHT*OUT_WIDTH*BITWIDTH bits, packed kernel-major; map 0 in the MSBs; within each map row-major; pixel (0,0) in the MSBs.
REQ-016 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, COLLECT and DONE.
REQ-018 IDLE SHALL drive in_ready=0 and out_valid=0; start=1 moves to COLLECT, clears the row/col counters to 0 and clears all feature_maps bits to 0 in the same edge.
REQ-019 COLLECT SHALL drive in_ready=1; a beat is accepted on a cycle with in_valid&&in_ready.
REQ-020 Accepted beat SHALL write slice k of in_data to map k at pixel (row,col), registered on that edge.
REQ-021 Counters SHALL advance per accepted beat: col+1; at col=OUT_WIDTH-1, col wraps to 0 and row increments.
REQ-022 Beat at (OUT_HEIGHT-1, OUT_WIDTH-1) SHALL move to DONE on the same edge; no further beats are accepted, and in_ready=0 from the next cycle.
REQ-023 Cycles with in_valid=0 in COLLECT SHALL hold counters and buffer unchanged; gaps of any length are allowed.
REQ-024 Requantization per element SHALL be: signed arithmetic shift right by SHIFT, then saturate to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1]; no rounding is applied.
REQ-025 DONE SHALL drive out_valid=1 with feature_maps stable; out_valid&&out_ready moves to IDLE the next edge; out_valid stays high indefinitely while out_ready=0.
REQ-026 feature_maps SHALL retain its last frame in IDLE until the next start.
REQ-027 start SHALL be ignored in COLLECT and DONE.
REQ-028 Minimum frame latency SHALL be: start edge, plus OUT_HEIGHT*OUT_WIDTH accepting cycles, then out_valid=1 on the cycle after the last beat.

Reset
REQ-029 rst=1 at a clock edge SHALL force state IDLE, row=col=0, feature_maps=0, in_ready=0, out_valid=0 and busy=0, and SHALL take priority over start, beats and out_ready.
REQ-030 Reset mid-COLLECT or mid-DONE SHALL discard the partial or complete frame; the next frame requires a new start.

Verification
REQ-031 SHALL verify a basic frame: defaults; start, then 9 consecutive beats with kernel k, pixel p value = p+1+16*k -> out_valid one cycle after beat 9; feature_maps = 72'h010203040506070809 for map 0, then 11..19 and 21..29 for maps 1 and 2.
REQ-032 SHALL verify saturation: SHIFT=0, a beat with values 300, -300 and -5 -> stored bytes 7F, 80 and FB; with SHIFT=2, value 300 -> 4B and value -5 -> FE.
REQ-033 SHALL verify backpressure: in_valid toggled every other cycle, and out_ready held low for 10 cycles after DONE -> identical frame to REQ-031; out_valid stays high for all 10 cycles; one handshake returns to IDLE.
REQ-034 SHALL verify reset mid-frame: rst pulsed after 4 accepted beats -> next cycle busy=0, in_ready=0, feature_maps=0; a new start and 9 beats yield a correct frame.
REQ-035 SHALL verify that start is ignored: start pulsed during COLLECT after beat 5 and during DONE -> counters not cleared; the frame completes normally.
REQ-036 SHALL verify non-square geometry: OUT_WIDTH=4, OUT_HEIGHT=2, KERNEL_NUM=1 -> col wraps after 4 beats; DONE after exactly 8 beats; feature_maps = 64'h0102030405060708.
